// File: rtl/circle_plotter_if.sv
// Interface between the control/location logic and the disc rasteriser.
// The master requests a draw; the slave reports status and drives the pixel-write bus.
interface circle_plotter_if;
    logic        start;
    logic        erase;
    logic [8:0]  cx;
    logic [7:0]  cy;
    logic [14:0] colour_in;
    logic        busy;
    logic        done;
    logic [8:0]  x_out;
    logic [7:0]  y_out;
    logic [14:0] colour_out;
    logic        plot;

    modport master (
        output start, erase, cx, cy, colour_in,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, erase, cx, cy, colour_in,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/circle_plotter.sv
// Rasterises one filled disc of RADIUS around (cx,cy), scanning the bounding
// square row-major and emitting one candidate pixel per clock to vga_adapter.
module circle_plotter #(
    parameter int RADIUS   = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic             clk,
    input  logic             reset,
    circle_plotter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [4:0]  R_POS  = 5'(RADIUS);
    localparam logic [4:0]  R_NEG  = ~R_POS + 5'd1;
    localparam logic [9:0]  R_SQ   = 10'(RADIUS * RADIUS);
    localparam logic [10:0] X_LIM  = 11'(SCREEN_W);
    localparam logic [10:0] Y_LIM  = 11'(SCREEN_H);

    state_t      r_state, w_state_next;
    logic [8:0]  r_cx;
    logic [7:0]  r_cy;
    logic [14:0] r_colour;
    logic [4:0]  r_dx, r_dy;
    logic        r_last;
    logic        r_busy, r_done, r_plot;
    logic [8:0]  r_x_out;
    logic [7:0]  r_y_out;
    logic [14:0] r_colour_out;

    // Offsets are two's-complement; sign-extended low bits give exact squares (max 225).
    logic [9:0]  w_dx_ext, w_dy_ext, w_dx_sq, w_dy_sq, w_dist_sq;
    logic [10:0] w_sx, w_sy;
    logic        w_inside;

    assign w_dx_ext  = {{5{r_dx[4]}}, r_dx};
    assign w_dy_ext  = {{5{r_dy[4]}}, r_dy};
    assign w_dx_sq   = w_dx_ext * w_dx_ext;
    assign w_dy_sq   = w_dy_ext * w_dy_ext;
    assign w_dist_sq = w_dx_sq + w_dy_sq;
    assign w_sx      = {2'b00, r_cx} + {{6{r_dx[4]}}, r_dx};
    assign w_sy      = {3'b000, r_cy} + {{6{r_dy[4]}}, r_dy};
    assign w_inside  = (w_dist_sq <= R_SQ)
                     && !w_sx[10] && (w_sx < X_LIM)
                     && !w_sy[10] && (w_sy < Y_LIM);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_SCAN;
            S_SCAN:  if (r_last)    w_state_next = S_DONE;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cx         <= '0;
            r_cy         <= '0;
            r_colour     <= '0;
            r_dx         <= R_NEG;
            r_dy         <= R_NEG;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_colour_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_plot <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_cx     <= bus.cx;
                        r_cy     <= bus.cy;
                        r_colour <= bus.erase ? 15'h0000 : bus.colour_in;
                        r_dx     <= R_NEG;
                        r_dy     <= R_NEG;
                        r_last   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_last) begin
                        r_plot <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_x_out      <= w_sx[8:0];
                        r_y_out      <= w_sy[7:0];
                        r_colour_out <= r_colour;
                        r_plot       <= w_inside;
                        if (r_dx == R_POS) begin
                            r_dx <= R_NEG;
                            if (r_dy == R_POS) r_last <= 1'b1;
                            else               r_dy   <= r_dy + 5'd1;
                        end else begin
                            r_dx <= r_dx + 5'd1;
                        end
                    end
                end
                default: begin
                    r_plot <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.plot       = r_plot;
    assign bus.x_out      = r_x_out;
    assign bus.y_out      = r_y_out;
    assign bus.colour_out = r_colour_out;

endmodule
